// File: rtl/clock_period_meter_if.sv
// rtl/clock_period_meter_if.sv - signal bundle between the measured input, the meter and its consumer
//
// Purpose: groups the measured signal and the measurement results of clock_period_meter.
// Signals:
//   i_sig        measured square wave, asynchronous to the meter clock
//   o_tick       1-cycle pulse per detected rising edge
//   o_valid      1-cycle pulse when o_period/o_high_time were just updated
//   o_period     last measured period in meter clock cycles
//   o_high_time  last measured high time in meter clock cycles
//   o_locked     measurements are current
//   o_timeout    input declared lost
// Modports: master = meter side, slave = source/consumer side.
interface clock_period_meter_if #(
    parameter int CNT_W = 32
);
    logic             i_sig;
    logic             o_tick;
    logic             o_valid;
    logic [CNT_W-1:0] o_period;
    logic [CNT_W-1:0] o_high_time;
    logic             o_locked;
    logic             o_timeout;

    modport master (
        input  i_sig,
        output o_tick, o_valid, o_period, o_high_time, o_locked, o_timeout
    );

    modport slave (
        output i_sig,
        input  o_tick, o_valid, o_period, o_high_time, o_locked, o_timeout
    );
endinterface

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - period / high-time meter for a slow free-running square wave
//
// Purpose: synchronises i_sig, detects rising edges, counts i_clk cycles per period and
// cycles spent high, publishes each completed measurement with a one-cycle o_valid and
// declares the input lost after TIMEOUT cycles without a rising edge.
// Ports:
//   i_clk      system clock, all logic on posedge
//   i_reset_n  asynchronous active-low reset
//   bus        clock_period_meter_if.master (i_sig in; o_tick, o_valid, o_period,
//              o_high_time, o_locked, o_timeout out; all outputs registered)
module clock_period_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    clock_period_meter_if.master  bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE, LOST} state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_dly_q;
    logic                   s;
    logic                   rise;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q, hcnt_q;
    logic [CNT_W-1:0]       cnt_d, hcnt_d;
    logic                   tick_q, valid_q, locked_q, timeout_q;
    logic [CNT_W-1:0]       period_q, high_q;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_dly_q;

    // Free-running increments; the high counter only advances while the
    // synchronised input is high. TIMEOUT <= 2**CNT_W-1 keeps cnt from wrapping.
    always_comb begin
        cnt_d  = cnt_q + 1'b1;
        hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, s};
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q  <= '0;
            s_dly_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.i_sig};
            s_dly_q <= s;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hcnt_q    <= '0;
            tick_q    <= 1'b0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            period_q  <= '0;
            high_q    <= '0;
        end else begin
            tick_q  <= rise;
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        cnt_q   <= CNT_W'(1);
                        hcnt_q  <= CNT_W'(1);
                        state_q <= ARMED;
                    end
                end
                ARMED, MEASURE: begin
                    // A rise on the TIMEOUT cycle is a valid measurement, not a loss.
                    if (rise) begin
                        cnt_q    <= CNT_W'(1);
                        hcnt_q   <= CNT_W'(1);
                        period_q <= cnt_q;
                        high_q   <= hcnt_q;
                        valid_q  <= 1'b1;
                        locked_q <= 1'b1;
                        state_q  <= MEASURE;
                    end else if (cnt_q == TIMEOUT_C) begin
                        timeout_q <= 1'b1;
                        locked_q  <= 1'b0;
                        period_q  <= '0;
                        high_q    <= '0;
                        state_q   <= LOST;
                    end else begin
                        cnt_q  <= cnt_d;
                        hcnt_q <= hcnt_d;
                    end
                end
                LOST: begin
                    // The first edge after loss only re-arms; the next one measures.
                    if (rise) begin
                        cnt_q     <= CNT_W'(1);
                        hcnt_q    <= CNT_W'(1);
                        timeout_q <= 1'b0;
                        state_q   <= ARMED;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_tick      = tick_q;
    assign bus.o_valid     = valid_q;
    assign bus.o_period    = period_q;
    assign bus.o_high_time = high_q;
    assign bus.o_locked    = locked_q;
    assign bus.o_timeout   = timeout_q;
endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - directed self-checking bench for clock_period_meter
module tb_clock_period_meter;
    localparam int CNT_W = 8;
    localparam int SS    = 2;
    localparam int TO    = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_period_meter_if #(.CNT_W(CNT_W)) bus ();

    clock_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int errors = 0;

    int   cyc = 0, tick_cnt = 0, valid_cnt = 0, tick_cyc = 0, to_cyc = 0;
    bit   to_seen = 0;
    logic to_prev = 1'b0;
    logic [CNT_W-1:0] per_q[$];
    logic [CNT_W-1:0] hi_q[$];

    always @(negedge clk) begin
        cyc++;
        if (bus.o_tick === 1'b1) begin
            tick_cnt++;
            tick_cyc = cyc;
        end
        if (bus.o_valid === 1'b1) begin
            valid_cnt++;
            per_q.push_back(bus.o_period);
            hi_q.push_back(bus.o_high_time);
        end
        if (bus.o_timeout === 1'b1 && to_prev !== 1'b1) begin
            to_seen = 1;
            to_cyc  = cyc;
        end
        to_prev = bus.o_timeout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        tick_cnt  = 0;
        valid_cnt = 0;
        to_seen   = 0;
        per_q.delete();
        hi_q.delete();
    endtask

    task automatic step(input logic v);
        bus.i_sig = v;
        @(negedge clk);
        #1;
    endtask

    task automatic run_wave(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < per; c++)
                step(c < hi);
    endtask

    task automatic test_reset();
        checks++; if (bus.o_tick !== 1'b0)      begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.o_tick); end
        checks++; if (bus.o_valid !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
        checks++; if (bus.o_period !== 8'd0)    begin errors++; $display("FAIL reset_period: got %0d expected 0", bus.o_period); end
        checks++; if (bus.o_high_time !== 8'd0) begin errors++; $display("FAIL reset_high: got %0d expected 0", bus.o_high_time); end
        checks++; if (bus.o_locked !== 1'b0)    begin errors++; $display("FAIL reset_locked: got %b expected 0", bus.o_locked); end
        checks++; if (bus.o_timeout !== 1'b0)   begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.o_timeout); end
        rst_n = 1'b1;
    endtask

    task automatic test_idle();
        clear_mon();
        repeat (50) step(1'b0);
        checks++; if (tick_cnt != 0)          begin errors++; $display("FAIL idle_tick: got %0d ticks expected 0", tick_cnt); end
        checks++; if (valid_cnt != 0)         begin errors++; $display("FAIL idle_valid: got %0d valids expected 0", valid_cnt); end
        checks++; if (to_seen || bus.o_timeout !== 1'b0) begin errors++; $display("FAIL idle_timeout: got %b expected 0", bus.o_timeout); end
    endtask

    task automatic test_period_10();
        clear_mon();
        run_wave(10, 5, 1);
        checks++; if (tick_cnt != 1)  begin errors++; $display("FAIL p10_first_tick: got %0d expected 1", tick_cnt); end
        checks++; if (valid_cnt != 0) begin errors++; $display("FAIL p10_first_valid: got %0d expected 0", valid_cnt); end
        run_wave(10, 5, 3);
        checks++; if (tick_cnt != 4)  begin errors++; $display("FAIL p10_ticks: got %0d expected 4", tick_cnt); end
        checks++; if (valid_cnt != 3) begin errors++; $display("FAIL p10_valids: got %0d expected 3", valid_cnt); end
        foreach (per_q[i]) begin
            checks++; if (per_q[i] !== 8'd10) begin errors++; $display("FAIL p10_period[%0d]: got %0d expected 10", i, per_q[i]); end
            checks++; if (hi_q[i] !== 8'd5)   begin errors++; $display("FAIL p10_high[%0d]: got %0d expected 5", i, hi_q[i]); end
        end
        checks++; if (bus.o_locked !== 1'b1) begin errors++; $display("FAIL p10_locked: got %b expected 1", bus.o_locked); end
    endtask

    task automatic test_switch_7();
        clear_mon();
        run_wave(7, 2, 4);
        checks++; if (valid_cnt != 4) begin errors++; $display("FAIL p7_valids: got %0d expected 4", valid_cnt); end
        for (int i = 1; i < per_q.size(); i++) begin
            checks++; if (per_q[i] !== 8'd7) begin errors++; $display("FAIL p7_period[%0d]: got %0d expected 7", i, per_q[i]); end
            checks++; if (hi_q[i] !== 8'd2)  begin errors++; $display("FAIL p7_high[%0d]: got %0d expected 2", i, hi_q[i]); end
        end
    endtask

    task automatic test_timeout();
        clear_mon();
        step(1'b1);
        step(1'b1);
        repeat (45) step(1'b0);
        checks++; if (!to_seen) begin errors++; $display("FAIL to_seen: got 0 expected 1"); end
        checks++; if (to_seen && (to_cyc - tick_cyc) != TO) begin errors++; $display("FAIL to_delay: got %0d expected %0d", to_cyc - tick_cyc, TO); end
        checks++; if (bus.o_timeout !== 1'b1)   begin errors++; $display("FAIL to_flag: got %b expected 1", bus.o_timeout); end
        checks++; if (bus.o_locked !== 1'b0)    begin errors++; $display("FAIL to_locked: got %b expected 0", bus.o_locked); end
        checks++; if (bus.o_period !== 8'd0)    begin errors++; $display("FAIL to_period: got %0d expected 0", bus.o_period); end
        checks++; if (bus.o_high_time !== 8'd0) begin errors++; $display("FAIL to_high: got %0d expected 0", bus.o_high_time); end
        clear_mon();
        run_wave(10, 5, 1);
        checks++; if (tick_cnt != 1)          begin errors++; $display("FAIL restart_tick: got %0d expected 1", tick_cnt); end
        checks++; if (valid_cnt != 0)         begin errors++; $display("FAIL restart_valid1: got %0d expected 0", valid_cnt); end
        checks++; if (bus.o_timeout !== 1'b0) begin errors++; $display("FAIL restart_timeout: got %b expected 0", bus.o_timeout); end
        run_wave(10, 5, 1);
        checks++; if (valid_cnt != 1)         begin errors++; $display("FAIL restart_valid2: got %0d expected 1", valid_cnt); end
        foreach (per_q[i]) begin
            checks++; if (per_q[i] !== 8'd10) begin errors++; $display("FAIL restart_period: got %0d expected 10", per_q[i]); end
        end
        checks++; if (bus.o_locked !== 1'b1)  begin errors++; $display("FAIL restart_locked: got %b expected 1", bus.o_locked); end
    endtask

    task automatic test_period_32();
        clear_mon();
        run_wave(32, 4, 3);
        checks++; if (to_seen || bus.o_timeout !== 1'b0) begin errors++; $display("FAIL p32_timeout: got %b expected 0", to_seen); end
        checks++; if (valid_cnt != 3) begin errors++; $display("FAIL p32_valids: got %0d expected 3", valid_cnt); end
        for (int i = 1; i < per_q.size(); i++) begin
            checks++; if (per_q[i] !== 8'd32) begin errors++; $display("FAIL p32_period[%0d]: got %0d expected 32", i, per_q[i]); end
            checks++; if (hi_q[i] !== 8'd4)   begin errors++; $display("FAIL p32_high[%0d]: got %0d expected 4", i, hi_q[i]); end
        end
        checks++; if (bus.o_locked !== 1'b1) begin errors++; $display("FAIL p32_locked: got %b expected 1", bus.o_locked); end
    endtask

    task automatic test_async_reset();
        run_wave(10, 5, 1);
        repeat (3) step(1'b1);
        checks++; if (bus.o_locked !== 1'b1) begin errors++; $display("FAIL pre_reset_locked: got %b expected 1", bus.o_locked); end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.o_period !== 8'd0)    begin errors++; $display("FAIL areset_period: got %0d expected 0", bus.o_period); end
        checks++; if (bus.o_high_time !== 8'd0) begin errors++; $display("FAIL areset_high: got %0d expected 0", bus.o_high_time); end
        checks++; if (bus.o_locked !== 1'b0)    begin errors++; $display("FAIL areset_locked: got %b expected 0", bus.o_locked); end
        checks++; if (bus.o_tick !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_timeout !== 1'b0) begin
            errors++; $display("FAIL areset_strobes: got tick=%b valid=%b timeout=%b expected 0", bus.o_tick, bus.o_valid, bus.o_timeout);
        end
        bus.i_sig = 1'b0;
        @(negedge clk);
        #1;
        repeat (2) step(1'b0);
        rst_n = 1'b1;
        repeat (3) step(1'b0);
        clear_mon();
        run_wave(10, 5, 1);
        checks++; if (tick_cnt != 1 || valid_cnt != 0) begin errors++; $display("FAIL post_reset_first: got ticks=%0d valids=%0d expected 1/0", tick_cnt, valid_cnt); end
        run_wave(10, 5, 2);
        checks++; if (valid_cnt != 2) begin errors++; $display("FAIL post_reset_valids: got %0d expected 2", valid_cnt); end
        foreach (per_q[i]) begin
            checks++; if (per_q[i] !== 8'd10 || hi_q[i] !== 8'd5) begin errors++; $display("FAIL post_reset_meas[%0d]: got %0d/%0d expected 10/5", i, per_q[i], hi_q[i]); end
        end
    endtask

    initial begin
        bus.i_sig = 1'b0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_idle();
        test_period_10();
        test_switch_7();
        test_timeout();
        test_period_32();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
